ama_riscv_id_ex_reg: RTL and testbench

//  ID/EX pipeline register. It captures decode-stage data, the controls, and the operand-forwarding selects computed in ID.
//  It detects load-use hazards, which EX-to-ID forwarding cannot cover, and inserts a bubble for them.
//  It honours a global hold and a branch flush, and keeps saturating stall and bubble counters.

---
 rtl/ama_riscv_id_ex_reg_if.sv | 63 ++++++
 rtl/ama_riscv_id_ex_reg.sv | 70 +++++++
 tb/tb_ama_riscv_id_ex_reg.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ama_riscv_id_ex_reg_if.sv
// ID/EX pipeline bundle: decode-side fields driven into the register and
// their registered EX-side copies.
interface ama_riscv_id_ex_reg_if #(
   parameter int XLEN = 32
);
   logic            inst_valid_id;
   logic [XLEN-1:0] pc_id;
   logic [XLEN-1:0] rs1_data_id;
   logic [XLEN-1:0] rs2_data_id;
   logic [XLEN-1:0] imm_id;
   logic [4:0]      rs1_id;
   logic [4:0]      rs2_id;
   logic [4:0]      rd_id;
   logic            reg_we_id;
   logic            load_inst_id;
   logic            store_inst_id;
   logic            branch_inst_id;
   logic [3:0]      alu_op_id;
   logic [1:0]      alu_a_sel_fwd_id;
   logic [1:0]      alu_b_sel_fwd_id;
   logic            bc_a_sel_fwd_id;
   logic            bcs_b_sel_fwd_id;

   logic            valid_ex;
   logic [XLEN-1:0] pc_ex;
   logic [XLEN-1:0] rs1_data_ex;
   logic [XLEN-1:0] rs2_data_ex;
   logic [XLEN-1:0] imm_ex;
   logic [4:0]      rs1_ex;
   logic [4:0]      rs2_ex;
   logic [4:0]      rd_ex;
   logic            reg_we_ex;
   logic            load_inst_ex;
   logic            store_inst_ex;
   logic            branch_inst_ex;
   logic [3:0]      alu_op_ex;
   logic [1:0]      alu_a_sel_fwd_ex;
   logic [1:0]      alu_b_sel_fwd_ex;
   logic            bc_a_sel_fwd_ex;
   logic            bcs_b_sel_fwd_ex;

   modport master (
      output inst_valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
             rs1_id, rs2_id, rd_id, reg_we_id, load_inst_id, store_inst_id,
             branch_inst_id, alu_op_id, alu_a_sel_fwd_id, alu_b_sel_fwd_id,
             bc_a_sel_fwd_id, bcs_b_sel_fwd_id,
      input  valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
             rs1_ex, rs2_ex, rd_ex, reg_we_ex, load_inst_ex, store_inst_ex,
             branch_inst_ex, alu_op_ex, alu_a_sel_fwd_ex, alu_b_sel_fwd_ex,
             bc_a_sel_fwd_ex, bcs_b_sel_fwd_ex
   );

   modport slave (
      input  inst_valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
             rs1_id, rs2_id, rd_id, reg_we_id, load_inst_id, store_inst_id,
             branch_inst_id, alu_op_id, alu_a_sel_fwd_id, alu_b_sel_fwd_id,
             bc_a_sel_fwd_id, bcs_b_sel_fwd_id,
      output valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
             rs1_ex, rs2_ex, rd_ex, reg_we_ex, load_inst_ex, store_inst_ex,
             branch_inst_ex, alu_op_ex, alu_a_sel_fwd_ex, alu_b_sel_fwd_ex,
             bc_a_sel_fwd_ex, bcs_b_sel_fwd_ex
   );
endinterface

// File: rtl/ama_riscv_id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, global hold,
// branch flush and saturating stall/bubble counters.
module ama_riscv_id_ex_reg #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_in,
   input  logic             flush,
   ama_riscv_id_ex_reg_if.slave bus,
   output logic             load_use_stall,
   output logic             stall_id,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);
   // valid + four XLEN words + three 5-bit regs + 4 flags + alu_op + 6 sel bits
   localparam int FW = 4*XLEN + 30;

   logic [FW-1:0]    id_bundle;
   logic [FW-1:0]    ex_reg;
   logic [FW-1:0]    ex_next;
   logic             bubble;
   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] bubble_cnt_reg;

   assign id_bundle = {bus.inst_valid_id, bus.pc_id, bus.rs1_data_id, bus.rs2_data_id,
                       bus.imm_id, bus.rs1_id, bus.rs2_id, bus.rd_id, bus.reg_we_id,
                       bus.load_inst_id, bus.store_inst_id, bus.branch_inst_id,
                       bus.alu_op_id, bus.alu_a_sel_fwd_id, bus.alu_b_sel_fwd_id,
                       bus.bc_a_sel_fwd_id, bus.bcs_b_sel_fwd_id};

   assign {bus.valid_ex, bus.pc_ex, bus.rs1_data_ex, bus.rs2_data_ex,
           bus.imm_ex, bus.rs1_ex, bus.rs2_ex, bus.rd_ex, bus.reg_we_ex,
           bus.load_inst_ex, bus.store_inst_ex, bus.branch_inst_ex,
           bus.alu_op_ex, bus.alu_a_sel_fwd_ex, bus.alu_b_sel_fwd_ex,
           bus.bc_a_sel_fwd_ex, bus.bcs_b_sel_fwd_ex} = ex_reg;

   // A flush already kills the dependent ID instr, so no stall is needed then.
   assign load_use_stall = bus.valid_ex & bus.load_inst_ex & (bus.rd_ex != 5'd0)
                         & bus.inst_valid_id & ~flush
                         & ((bus.rs1_id == bus.rd_ex) | (bus.rs2_id == bus.rd_ex));
   assign stall_id   = load_use_stall | stall_in;
   assign bubble     = ~stall_in & (flush | load_use_stall);
   assign stall_cnt  = stall_cnt_reg;
   assign bubble_cnt = bubble_cnt_reg;

   always_comb begin
      ex_next = ex_reg;
      if (!stall_in) begin
         ex_next = bubble ? '0 : id_bundle;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_reg         <= '0;
         stall_cnt_reg  <= '0;
         bubble_cnt_reg <= '0;
      end else begin
         ex_reg <= ex_next;
         if (stall_id && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         end
         if (bubble && (bubble_cnt_reg != '1)) begin
            bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ama_riscv_id_ex_reg.sv
// Directed bench for the ID/EX register: a per-cycle behavioural model check
// plus literal expectations for the load-use, flush, hold and saturation cases.
module tb_ama_riscv_id_ex_reg;
   localparam int XLEN    = 32;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef logic [159:0] wv_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_we;
      logic        load;
      logic        store;
      logic        branch;
      logic [3:0]  alu_op;
      logic [1:0]  a_sel;
      logic [1:0]  b_sel;
      logic        bc_a;
      logic        bcs_b;
   } inst_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             stall_in = 1'b0;
   logic             flush = 1'b0;
   logic             load_use_stall;
   logic             stall_id;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] bubble_cnt;

   int n_cmp = 0;
   int n_err = 0;

   inst_t m_ex = '0;
   logic  m_valid = 1'b0;
   int    m_sc = 0;
   int    m_bc = 0;

   ama_riscv_id_ex_reg_if #(.XLEN(XLEN)) intf ();

   ama_riscv_id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_in       (stall_in),
      .flush          (flush),
      .bus            (intf),
      .load_use_stall (load_use_stall),
      .stall_id       (stall_id),
      .stall_cnt      (stall_cnt),
      .bubble_cnt     (bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input wv_t act, input wv_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic inst_t id_now();
      inst_t i;
      i.pc = intf.pc_id;         i.rs1_data = intf.rs1_data_id;
      i.rs2_data = intf.rs2_data_id; i.imm = intf.imm_id;
      i.rs1 = intf.rs1_id;       i.rs2 = intf.rs2_id;   i.rd = intf.rd_id;
      i.reg_we = intf.reg_we_id; i.load = intf.load_inst_id;
      i.store = intf.store_inst_id; i.branch = intf.branch_inst_id;
      i.alu_op = intf.alu_op_id; i.a_sel = intf.alu_a_sel_fwd_id;
      i.b_sel = intf.alu_b_sel_fwd_id; i.bc_a = intf.bc_a_sel_fwd_id;
      i.bcs_b = intf.bcs_b_sel_fwd_id;
      return i;
   endfunction

   function automatic inst_t ex_now();
      inst_t i;
      i.pc = intf.pc_ex;         i.rs1_data = intf.rs1_data_ex;
      i.rs2_data = intf.rs2_data_ex; i.imm = intf.imm_ex;
      i.rs1 = intf.rs1_ex;       i.rs2 = intf.rs2_ex;   i.rd = intf.rd_ex;
      i.reg_we = intf.reg_we_ex; i.load = intf.load_inst_ex;
      i.store = intf.store_inst_ex; i.branch = intf.branch_inst_ex;
      i.alu_op = intf.alu_op_ex; i.a_sel = intf.alu_a_sel_fwd_ex;
      i.b_sel = intf.alu_b_sel_fwd_ex; i.bc_a = intf.bc_a_sel_fwd_ex;
      i.bcs_b = intf.bcs_b_sel_fwd_ex;
      return i;
   endfunction

   task automatic drive(input inst_t i, input logic v);
      intf.inst_valid_id = v;
      intf.pc_id = i.pc;           intf.rs1_data_id = i.rs1_data;
      intf.rs2_data_id = i.rs2_data; intf.imm_id = i.imm;
      intf.rs1_id = i.rs1;         intf.rs2_id = i.rs2;   intf.rd_id = i.rd;
      intf.reg_we_id = i.reg_we;   intf.load_inst_id = i.load;
      intf.store_inst_id = i.store; intf.branch_inst_id = i.branch;
      intf.alu_op_id = i.alu_op;   intf.alu_a_sel_fwd_id = i.a_sel;
      intf.alu_b_sel_fwd_id = i.b_sel; intf.bc_a_sel_fwd_id = i.bc_a;
      intf.bcs_b_sel_fwd_id = i.bcs_b;
   endtask

   function automatic inst_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic ld);
      inst_t i;
      i.pc = pc;  i.rs1 = rs1;  i.rs2 = rs2;  i.rd = rd;
      i.rs1_data = $urandom;  i.rs2_data = $urandom;  i.imm = $urandom;
      i.reg_we = 1'b1;  i.load = ld;
      i.store = 1'(pc[2]);  i.branch = 1'(pc[3]);
      i.alu_op = 4'($urandom_range(15));
      i.a_sel = 2'($urandom_range(3));  i.b_sel = 2'($urandom_range(3));
      i.bc_a = 1'($urandom_range(1));   i.bcs_b = 1'($urandom_range(1));
      return i;
   endfunction

   // Load-use rule evaluated against the model's own EX contents.
   function automatic logic hazard_now();
      return m_valid && m_ex.load && (m_ex.rd != 5'd0) && intf.inst_valid_id && !flush
             && ((intf.rs1_id == m_ex.rd) || (intf.rs2_id == m_ex.rd));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ex <= '0;  m_valid <= 1'b0;  m_sc <= 0;  m_bc <= 0;
      end else begin
         if ((stall_in || hazard_now()) && (m_sc < CNT_MAX)) m_sc <= m_sc + 1;
         if (!stall_in) begin
            if (flush || hazard_now()) begin
               m_ex <= '0;  m_valid <= 1'b0;
               if (m_bc < CNT_MAX) m_bc <= m_bc + 1;
            end else begin
               m_ex <= id_now();  m_valid <= intf.inst_valid_id;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("model_ex_fields", wv_t'(ex_now()), wv_t'(m_ex));
      chk("model_valid_ex", wv_t'(intf.valid_ex), wv_t'(m_valid));
      chk("model_load_use", wv_t'(load_use_stall), wv_t'(hazard_now()));
      chk("model_stall_id", wv_t'(stall_id), wv_t'(hazard_now() || stall_in));
      chk("model_stall_cnt", wv_t'(stall_cnt), wv_t'(m_sc));
      chk("model_bubble_cnt", wv_t'(bubble_cnt), wv_t'(m_bc));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;  stall_in = 1'b0;  flush = 1'b0;
      drive('0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      drive('0, 1'b0);

      // Reset release with a valid instruction waiting in ID.
      drive(mk(32'h100, 5'd1, 5'd2, 5'd3, 1'b0), 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pc_ex", wv_t'(intf.pc_ex), wv_t'(32'h0));
      chk("rst_valid_ex", wv_t'(intf.valid_ex), wv_t'(1'b0));
      rst_n = 1'b1;
      step();
      @(negedge clk);
      chk("t1_pc_ex", wv_t'(intf.pc_ex), wv_t'(32'h100));
      chk("t1_valid_ex", wv_t'(intf.valid_ex), wv_t'(1'b1));
      $display("t1 reset release pc_ex=%0h valid_ex=%0b", intf.pc_ex, intf.valid_ex);
      for (int k = 0; k < 6; k++) begin
         step();
         drive(mk(32'h104 + 32'(4 * k), 5'(k + 1), 5'(k + 9), 5'(k + 17), 1'b0), 1'(k != 3));
      end
      step();

      // Load x5 followed by a dependent add: one bubble, then the add.
      do_reset();
      drive(mk(32'h200, 5'd1, 5'd0, 5'd5, 1'b1), 1'b1);
      step();
      drive(mk(32'h204, 5'd3, 5'd5, 5'd6, 1'b0), 1'b1);
      @(negedge clk);
      chk("t2_load_use", wv_t'(load_use_stall), wv_t'(1'b1));
      chk("t2_stall_id", wv_t'(stall_id), wv_t'(1'b1));
      step();
      @(negedge clk);
      chk("t2_bubble_valid", wv_t'(intf.valid_ex), wv_t'(1'b0));
      chk("t2_bubble_reg_we", wv_t'(intf.reg_we_ex), wv_t'(1'b0));
      step();
      @(negedge clk);
      chk("t2_add_pc", wv_t'(intf.pc_ex), wv_t'(32'h204));
      chk("t2_add_valid", wv_t'(intf.valid_ex), wv_t'(1'b1));
      chk("t2_bubble_cnt", wv_t'(bubble_cnt), wv_t'(1));
      chk("t2_stall_cnt", wv_t'(stall_cnt), wv_t'(1));
      $display("t2 load-use bubble_cnt=%0d stall_cnt=%0d", bubble_cnt, stall_cnt);

      // Load into x0 never stalls a reader of x0.
      step();
      drive(mk(32'h300, 5'd2, 5'd0, 5'd0, 1'b1), 1'b1);
      step();
      drive(mk(32'h304, 5'd0, 5'd0, 5'd7, 1'b0), 1'b1);
      @(negedge clk);
      chk("t3_load_use", wv_t'(load_use_stall), wv_t'(1'b0));
      step();
      @(negedge clk);
      chk("t3_pc_ex", wv_t'(intf.pc_ex), wv_t'(32'h304));
      chk("t3_valid_ex", wv_t'(intf.valid_ex), wv_t'(1'b1));
      $display("t3 x0 load pc_ex=%0h", intf.pc_ex);

      // Hazard coinciding with flush: single bubble, no stall.
      do_reset();
      drive(mk(32'h400, 5'd1, 5'd2, 5'd7, 1'b1), 1'b1);
      step();
      drive(mk(32'h404, 5'd7, 5'd1, 5'd8, 1'b0), 1'b1);
      flush = 1'b1;
      @(negedge clk);
      chk("t4_load_use", wv_t'(load_use_stall), wv_t'(1'b0));
      chk("t4_stall_id", wv_t'(stall_id), wv_t'(1'b0));
      step();
      flush = 1'b0;
      drive(mk(32'h408, 5'd2, 5'd3, 5'd9, 1'b0), 1'b1);
      @(negedge clk);
      chk("t4_valid_ex", wv_t'(intf.valid_ex), wv_t'(1'b0));
      chk("t4_bubble_cnt", wv_t'(bubble_cnt), wv_t'(1));
      chk("t4_stall_cnt", wv_t'(stall_cnt), wv_t'(0));
      step();
      @(negedge clk);
      chk("t4_pc_ex", wv_t'(intf.pc_ex), wv_t'(32'h408));
      $display("t4 flush+hazard bubble_cnt=%0d stall_cnt=%0d", bubble_cnt, stall_cnt);

      // Hold beats flush; the flush bubble lands once the hold drops.
      do_reset();
      drive(mk(32'h500, 5'd1, 5'd2, 5'd3, 1'b0), 1'b1);
      step();
      stall_in = 1'b1;  flush = 1'b1;
      drive(mk(32'h504, 5'd4, 5'd5, 5'd6, 1'b0), 1'b1);
      repeat (3) step();
      @(negedge clk);
      chk("t5_hold_pc", wv_t'(intf.pc_ex), wv_t'(32'h500));
      chk("t5_hold_valid", wv_t'(intf.valid_ex), wv_t'(1'b1));
      chk("t5_stall_cnt", wv_t'(stall_cnt), wv_t'(3));
      step();
      stall_in = 1'b0;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("t5_flush_valid", wv_t'(intf.valid_ex), wv_t'(1'b0));
      chk("t5_bubble_cnt", wv_t'(bubble_cnt), wv_t'(1));
      chk("t5_stall_cnt_after", wv_t'(stall_cnt), wv_t'(4));
      $display("t5 hold+flush stall_cnt=%0d bubble_cnt=%0d", stall_cnt, bubble_cnt);

      // Saturation at 2^CNT_W-1, then asynchronous reset mid-hold.
      do_reset();
      drive(mk(32'h600, 5'd1, 5'd2, 5'd3, 1'b0), 1'b1);
      step();
      stall_in = 1'b1;
      repeat (20) step();
      @(negedge clk);
      chk("t6_stall_sat", wv_t'(stall_cnt), wv_t'(15));
      chk("t6_hold_pc", wv_t'(intf.pc_ex), wv_t'(32'h600));
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_fields", wv_t'(ex_now()), wv_t'(0));
      chk("t6_rst_valid", wv_t'(intf.valid_ex), wv_t'(1'b0));
      chk("t6_rst_stall_cnt", wv_t'(stall_cnt), wv_t'(0));
      chk("t6_rst_bubble_cnt", wv_t'(bubble_cnt), wv_t'(0));
      $display("t6 saturate+async reset stall_cnt=%0d", stall_cnt);
      do_reset();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
